// File: rtl/cam_capture_pkt_if.sv
// Sensor-side byte stream and packed-word output bus of the DVP capture stage.
interface cam_capture_pkt_if #(
    parameter int OUT_W = 128
);
    logic             vsync;
    logic             href;
    logic [7:0]       din;
    logic [OUT_W-1:0] dout;
    logic             dout_vld;
    logic             dout_sop;
    logic             dout_eop;
    logic             dout_err;

    modport master (
        input  vsync, href, din,
        output dout, dout_vld, dout_sop, dout_eop, dout_err
    );

    modport slave (
        output vsync, href, din,
        input  dout, dout_vld, dout_sop, dout_eop, dout_err
    );
endinterface

// File: rtl/cam_capture_pkt.sv
// DVP camera capture: frames pclk-domain bytes with vsync/href, packs OUT_W-bit words, checks geometry.
// Optional built-in RGB565 test pattern when CAP_TEST_PATTERN_EN is defined (adds input tp_sel).
module cam_capture_pkt #(
    parameter int H_ACT = 1280,
    parameter int V_ACT = 720,
    parameter int BPP   = 2,
    parameter int OUT_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
`ifdef CAP_TEST_PATTERN_EN
    input  logic              tp_sel,
`endif
    cam_capture_pkt_if.master bus,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        err_cnt
);
    localparam int HB = H_ACT * BPP;
    localparam int W  = OUT_W / 8;
    localparam int HW = $clog2(HB + 1);
    localparam int VW = $clog2(V_ACT + 1);
    localparam int BW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic             vs_s1, vs_s2, vs_rise, vs_fall;
    logic [HW-1:0]    cnt_h;
    logic [VW-1:0]    cnt_v;
    logic [BW-1:0]    b_idx;
    logic             line_end;
    logic [OUT_W-1:0] sh, wnext;
    logic [7:0]       byte_in;
    logic             accept, abort, take, line_last, frame_last, word_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
        end else begin
            vs_s1 <= bus.vsync;
            vs_s2 <= vs_s1;
        end
    end

    assign vs_rise = vs_s1 & ~vs_s2;
    assign vs_fall = ~vs_s1 & vs_s2;

`ifdef CAP_TEST_PATTERN_EN
    logic [15:0] tp_pix;
    always_comb begin
        if (int'(cnt_v) < V_ACT / 4)            tp_pix = 16'hF800;
        else if (int'(cnt_v) < V_ACT / 2)       tp_pix = 16'h07E0;
        else if (int'(cnt_v) < (3 * V_ACT) / 4) tp_pix = 16'h001F;
        else                                    tp_pix = 16'hF81F;
    end
    assign byte_in = tp_sel ? (cnt_h[0] ? tp_pix[15:8] : tp_pix[7:0]) : bus.din;
`else
    assign byte_in = bus.din;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        abort      = 1'b0;
        line_last  = 1'b0;
        frame_last = 1'b0;
        case (state)
            IDLE:    if (enable) state_nxt = WAIT_VS;
            WAIT_VS: begin
                if (!enable)      state_nxt = IDLE;
                else if (vs_fall) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (bus.href && line_end)            abort = 1'b1;
                else if (!bus.href && cnt_h != '0)   abort = 1'b1;
                else if (bus.href) begin
                    accept     = 1'b1;
                    line_last  = (cnt_h == HW'(HB - 1));
                    frame_last = line_last && (cnt_v == VW'(V_ACT - 1));
                end
                // a frame finishing on the same edge as vsync rising is still good
                if (vs_rise && !frame_last) abort = 1'b1;
                if (abort || frame_last) state_nxt = WAIT_VS;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign take      = accept && !abort;
    assign word_done = take && (b_idx == BW'(W - 1));
    assign busy      = (state == ACTIVE);

    always_comb begin
        wnext = sh;
        for (int i = 0; i < W; i++)
            if (b_idx == BW'(i)) wnext[i*8 +: 8] = byte_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_h        <= '0;
            cnt_v        <= '0;
            b_idx        <= '0;
            line_end     <= 1'b0;
            sh           <= '0;
            bus.dout     <= '0;
            bus.dout_vld <= 1'b0;
            bus.dout_sop <= 1'b0;
            bus.dout_eop <= 1'b0;
            bus.dout_err <= 1'b0;
            frame_cnt    <= '0;
            err_cnt      <= '0;
        end else begin
            bus.dout_vld <= 1'b0;
            bus.dout_sop <= 1'b0;
            bus.dout_eop <= 1'b0;
            bus.dout_err <= abort;
            if (abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

            if (state == WAIT_VS && state_nxt == ACTIVE) begin
                cnt_h    <= '0;
                cnt_v    <= '0;
                b_idx    <= '0;
                line_end <= 1'b0;
            end else if (take) begin
                sh       <= wnext;
                cnt_h    <= line_last ? '0 : cnt_h + HW'(1);
                b_idx    <= (b_idx == BW'(W - 1)) ? '0 : b_idx + BW'(1);
                line_end <= line_last;
                if (line_last && !frame_last) cnt_v <= cnt_v + VW'(1);
                if (frame_last) frame_cnt <= frame_cnt + 16'd1;
                if (word_done) begin
                    bus.dout     <= wnext;
                    bus.dout_vld <= 1'b1;
                    bus.dout_sop <= (cnt_v == '0) && (cnt_h == HW'(W - 1));
                    bus.dout_eop <= frame_last;
                end
            end else if (state == ACTIVE && !bus.href) begin
                line_end <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cam_capture_pkt.sv
// Directed bench for cam_capture_pkt: H_ACT=8, V_ACT=4, BPP=2, OUT_W=32 (4 words/line, 16/frame).
module tb_cam_capture_pkt;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`ifdef CAP_TEST_PATTERN_EN
    logic        tp_sel = 1'b0;
`endif

    int nvec = 0;
    int nerr = 0;

    cam_capture_pkt_if #(.OUT_W(32)) vif ();

    cam_capture_pkt #(.H_ACT(8), .V_ACT(4), .BPP(2), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
`ifdef CAP_TEST_PATTERN_EN
        .tp_sel    (tp_sel),
`endif
        .bus       (vif.master),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // word/flag log captured away from the active edge
    logic [31:0] wq[$];
    bit          sq[$];
    bit          eq[$];
    int          errs_seen = 0;

    always @(negedge clk) begin
        if (vif.dout_vld) begin
            wq.push_back(vif.dout);
            sq.push_back(vif.dout_sop);
            eq.push_back(vif.dout_eop);
        end
        if (vif.dout_err) errs_seen++;
    end

    `define CHK(tag, obs, exp) begin \
        nvec++; \
        assert ((obs) === (exp)) else begin \
            nerr++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); vif.href = 1'b0; end
    endtask

    task automatic frame_start();
        @(negedge clk); vif.vsync = 1'b1;
        idle(4);
        vif.vsync = 1'b0;
        idle(4);
    endtask

    task automatic frame_end();
        @(negedge clk); vif.vsync = 1'b1;
        idle(4);
    endtask

    task automatic send_line(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vif.href = 1'b1;
            vif.din  = base + 8'(i);
        end
        idle(3);
    endtask

    task automatic full_frame();
        frame_start();
        for (int l = 0; l < 4; l++) send_line(16, 8'(l * 16));
        frame_end();
    endtask

    function automatic int count_flags(input int from, input bit use_eop);
        int c = 0;
        for (int i = from; i < wq.size(); i++) c += use_eop ? int'(eq[i]) : int'(sq[i]);
        return c;
    endfunction

    int w0, e0;

    initial begin
        vif.vsync = 1'b1;
        vif.href  = 1'b0;
        vif.din   = 8'h00;
        repeat (3) @(negedge clk);
        `CHK("rst_dout", vif.dout, 32'h0)
        `CHK("rst_vld", vif.dout_vld, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_frame_cnt", frame_cnt, 16'd0)
        `CHK("rst_err_cnt", err_cnt, 8'd0)
        rst_n  = 1'b1;
        enable = 1'b1;
        idle(2);

        // nominal frame
        w0 = wq.size(); e0 = errs_seen;
        full_frame();
        `CHK("nom_words", wq.size() - w0, 16)
        `CHK("nom_w0", wq[w0], 32'h03020100)
        `CHK("nom_sop0", sq[w0], 1'b1)
        `CHK("nom_sop_total", count_flags(w0, 1'b0), 1)
        `CHK("nom_w5", wq[w0+5], 32'h17161514)
        `CHK("nom_w15", wq[w0+15], 32'h3F3E3D3C)
        `CHK("nom_eop15", eq[w0+15], 1'b1)
        `CHK("nom_eop_total", count_flags(w0, 1'b1), 1)
        `CHK("nom_frame_cnt", frame_cnt, 16'd1)
        `CHK("nom_no_err", errs_seen - e0, 0)
        `CHK("nom_busy", busy, 1'b0)

        // short line: line 1 stops after 10 bytes
        w0 = wq.size(); e0 = errs_seen;
        frame_start();
        send_line(16, 8'h00);
        send_line(10, 8'h10);
        send_line(16, 8'h20);
        frame_end();
        `CHK("short_err_pulses", errs_seen - e0, 1)
        `CHK("short_err_cnt", err_cnt, 8'd1)
        `CHK("short_words", wq.size() - w0, 6)
        `CHK("short_no_eop", count_flags(w0, 1'b1), 0)
        w0 = wq.size();
        full_frame();
        `CHK("recover_words", wq.size() - w0, 16)
        `CHK("recover_w0", wq[w0], 32'h03020100)
        `CHK("recover_eop", eq[w0+15], 1'b1)
        `CHK("recover_frame_cnt", frame_cnt, 16'd2)

        // long line of 17 bytes
        w0 = wq.size(); e0 = errs_seen;
        frame_start();
        send_line(17, 8'h00);
        frame_end();
        `CHK("long_err_pulses", errs_seen - e0, 1)
        `CHK("long_err_cnt", err_cnt, 8'd2)
        `CHK("long_words", wq.size() - w0, 4)

        // short frame: vsync rises after line 2
        w0 = wq.size(); e0 = errs_seen;
        frame_start();
        send_line(16, 8'h00);
        send_line(16, 8'h10);
        frame_end();
        `CHK("sframe_err_pulses", errs_seen - e0, 1)
        `CHK("sframe_err_cnt", err_cnt, 8'd3)
        `CHK("sframe_words", wq.size() - w0, 8)
        `CHK("sframe_no_eop", count_flags(w0, 1'b1), 0)

        // drive error counter to saturation: 257 aborts in total
        e0 = errs_seen;
        for (int k = 0; k < 254; k++) begin
            frame_start();
            send_line(3, 8'h00);
            if (k == 251) `CHK("sat_at_255", err_cnt, 8'd255)
        end
        `CHK("sat_pulses", errs_seen - e0, 254)
        `CHK("sat_err_cnt", err_cnt, 8'd255)
        frame_end();

        // enable drops mid-frame: frame still completes
        w0 = wq.size();
        frame_start();
        send_line(16, 8'h00);
        send_line(16, 8'h10);
        enable = 1'b0;
        send_line(16, 8'h20);
        send_line(16, 8'h30);
        frame_end();
        `CHK("en_words", wq.size() - w0, 16)
        `CHK("en_eop", eq[w0+15], 1'b1)
        `CHK("en_frame_cnt", frame_cnt, 16'd3)
        w0 = wq.size();
        full_frame();
        `CHK("disabled_words", wq.size() - w0, 0)
        `CHK("disabled_frame_cnt", frame_cnt, 16'd3)
        enable = 1'b1;
        idle(2);
        w0 = wq.size();
        full_frame();
        `CHK("reenable_words", wq.size() - w0, 16)
        `CHK("reenable_frame_cnt", frame_cnt, 16'd4)

        // asynchronous reset in the middle of line 1
        frame_start();
        send_line(16, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); vif.href = 1'b1; vif.din = 8'h10 + 8'(i);
        end
        #2 rst_n = 1'b0;
        #1;
        `CHK("mrst_dout", vif.dout, 32'h0)
        `CHK("mrst_busy", busy, 1'b0)
        `CHK("mrst_frame_cnt", frame_cnt, 16'd0)
        `CHK("mrst_err_cnt", err_cnt, 8'd0)
        `CHK("mrst_vld", vif.dout_vld, 1'b0)
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w0 = wq.size(); e0 = errs_seen;
        send_line(10, 8'h16);
        send_line(16, 8'h20);
        send_line(16, 8'h30);
        `CHK("mrst_no_words", wq.size() - w0, 0)
        frame_end();
        full_frame();
        `CHK("mrst_words", wq.size() - w0, 16)
        `CHK("mrst_w0", wq[w0], 32'h03020100)
        `CHK("mrst_sop", sq[w0], 1'b1)
        `CHK("mrst_frame_cnt2", frame_cnt, 16'd1)
        `CHK("mrst_no_err", errs_seen - e0, 0)

`ifdef CAP_TEST_PATTERN_EN
        tp_sel = 1'b1;
        w0 = wq.size();
        full_frame();
        `CHK("tp_words", wq.size() - w0, 16)
        `CHK("tp_line0", wq[w0], 32'hF800F800)
        `CHK("tp_line1", wq[w0+4], 32'h07E007E0)
        `CHK("tp_line2", wq[w0+8], 32'h001F001F)
        `CHK("tp_line3", wq[w0+12], 32'hF81FF81F)
        tp_sel = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
